// File: rtl/ysyx_24100006_pkg.sv
// Shared FSM state type, default memory window and the pmem access interface used by the SRAM front end.
// pmem_read/pmem_write are backed by a sparse SV word store.
package ysyx_24100006_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } sram_state_e;

  localparam logic [31:0] PMEM_BASE = 32'h8000_0000;
  localparam logic [31:0] PMEM_SIZE = 32'h0800_0000;
  localparam logic [7:0]  LFSR_SEED = 8'hA5;

  int unsigned pmem_calls = 0;
  int          pmem_words [int];

  function automatic int pmem_read(input int raddr);
    pmem_calls++;
    if (pmem_words.exists(raddr & ~3)) return pmem_words[raddr & ~3];
    return 0;
  endfunction

  function automatic void pmem_write(input int waddr, input int wdata, input byte wmask);
    int w;
    pmem_calls++;
    w = pmem_words.exists(waddr & ~3) ? pmem_words[waddr & ~3] : 0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (wmask[i]) w[8*i +: 8] = wdata[8*i +: 8];
    end
    pmem_words[waddr & ~3] = w;
  endfunction

endpackage

// File: rtl/ysyx_24100006_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that advances once per accepted request.
module ysyx_24100006_lfsr
  import ysyx_24100006_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv_i) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/ysyx_24100006_sram.sv
// Single-outstanding SRAM front end: request/response handshake, programmable latency, window/alignment fault checking.
// Define YSYX_24100006_SRAM_RAND_DELAY_EN to draw each access latency from an LFSR instead of the fixed LATENCY.
module ysyx_24100006_sram
  import ysyx_24100006_pkg::*;
#(
  parameter int unsigned   DW      = 32,
  parameter int unsigned   AW      = 32,
  parameter int unsigned   LATENCY = 1,
  parameter logic [AW-1:0] BASE    = AW'(PMEM_BASE),
  parameter logic [AW-1:0] SIZE    = AW'(PMEM_SIZE)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_wmask,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err
);

  localparam int unsigned NB  = DW / 8;
  localparam int unsigned OFW = $clog2(NB);
  localparam int unsigned XW  = AW + 1;
  localparam int unsigned CW  = 4;

  sram_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, load_val;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]   wmask_q, wmask_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [DW-1:0]   rsp_rdata_q;

  logic            accept, enter_resp;
  logic            acc_we, acc_err;
  logic [AW-1:0]   acc_addr;
  logic [DW-1:0]   acc_wdata;
  logic [NB-1:0]   acc_wmask;
  logic [XW-1:0]   acc_end, win_end;

  assign accept = req_valid & req_ready_q;

`ifdef YSYX_24100006_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_val;

  ysyx_24100006_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .adv_i  (accept),
    .lfsr_o (lfsr_val)
  );

  assign load_val = CW'(32'(lfsr_val) % LATENCY);
`else
  assign load_val = CW'(LATENCY - 1);
`endif

  // A zero latency load enters RESP on the accept edge, so the access uses the live request.
  always_comb begin
    acc_we    = accept ? req_we    : we_q;
    acc_addr  = accept ? req_addr  : addr_q;
    acc_wdata = accept ? req_wdata : wdata_q;
    acc_wmask = accept ? req_wmask : wmask_q;
    acc_end   = XW'(acc_addr) + XW'(NB);
    win_end   = XW'(BASE) + XW'(SIZE);
    acc_err   = (acc_addr < BASE) || (acc_end > win_end) || (acc_addr[OFW-1:0] != '0);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          cnt_d   = load_val;
          if (load_val == '0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1)) begin
          cnt_d      = '0;
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    if (enter_resp)             rsp_err_d = acc_err;
    else if (state_d == ST_RESP) rsp_err_d = rsp_err_q;
    else                         rsp_err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Wide accesses split into 32-bit words, low word first.
  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DW / 32; i++) begin
      r[32*i +: 32] = pmem_read(32'(a + AW'(4 * i)));
    end
    return r;
  endfunction

  function automatic void mem_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                    input logic [NB-1:0] m);
    for (int unsigned i = 0; i < DW / 32; i++) begin
      pmem_write(32'(a + AW'(4 * i)), d[32*i +: 32], {4'b0000, m[4*i +: 4]});
    end
  endfunction

  // Memory calls have side effects and must fire exactly once per edge, so they sit here, not in always_comb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata_q <= '0;
    end else if (enter_resp) begin
      if (acc_err) begin
        rsp_rdata_q <= '0;
      end else if (acc_we) begin
        rsp_rdata_q <= '0;
        if (acc_wmask != '0) mem_write(acc_addr, acc_wdata, acc_wmask);
      end else begin
        rsp_rdata_q <= mem_read(acc_addr);
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ysyx_24100006_sram.sv
// Directed bench for ysyx_24100006_sram: a 32-bit LATENCY=3 instance and a 64-bit LATENCY=1 instance.
module tb_ysyx_24100006_sram;
  import ysyx_24100006_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        a_req_valid = 1'b0, a_req_we = 1'b0, a_rsp_ready = 1'b0;
  logic [31:0] a_req_addr = '0, a_req_wdata = '0;
  logic [3:0]  a_req_wmask = '0;
  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;

  logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_rsp_ready = 1'b0;
  logic [31:0] b_req_addr = '0;
  logic [63:0] b_req_wdata = '0;
  logic [7:0]  b_req_wmask = '0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [63:0] b_rsp_rdata;

  ysyx_24100006_sram #(.DW(32), .AW(32), .LATENCY(3)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wmask(a_req_wmask),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  ysyx_24100006_sram #(.DW(64), .AW(32), .LATENCY(1)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic do32(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] mask, output logic [31:0] rdata, output logic err,
                      output int lat);
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_wmask = mask;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    lat = 1;
    while (!a_rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!a_rsp_valid) check("rsp32_timeout", 64'd0, 64'd1);
    rdata = a_rsp_rdata; err = a_rsp_err;
    a_rsp_ready = 1'b1; @(posedge clk); #1; a_rsp_ready = 1'b0;
  endtask

  task automatic do64(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                      input logic [7:0] mask, output logic [63:0] rdata, output logic err,
                      output int lat);
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata; b_req_wmask = mask;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    lat = 1;
    while (!b_rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!b_rsp_valid) check("rsp64_timeout", 64'd0, 64'd1);
    rdata = b_rsp_rdata; err = b_rsp_err;
    b_rsp_ready = 1'b1; @(posedge clk); #1; b_rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [63:0] rd64;
    logic        er;
    int          lat;
    int unsigned c0;

    pmem_write(32'h8000_0000, 32'h1234_5678, 8'h0F);
    pmem_write(32'h8000_0010, 32'hCAFE_F00D, 8'h0F);

    // Asynchronous reset takes effect without a clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_req_ready", 64'(a_req_ready), 64'd0);
    check("rst_rsp_valid", 64'(a_rsp_valid), 64'd0);
    check("rst_rsp_err",   64'(a_rsp_err),   64'd0);
    check("rst_rsp_rdata", 64'(a_rsp_rdata), 64'd0);
    check("rst64_rdata",   b_rsp_rdata,      64'd0);
    #10 rst_n = 1'b1;
    #1;
    check("ready_before_edge", 64'(a_req_ready), 64'd0);
    @(posedge clk); #1;
    check("ready_after_edge",   64'(a_req_ready), 64'd1);
    check("ready64_after_edge", 64'(b_req_ready), 64'd1);

    do32(1'b0, 32'h8000_0000, '0, '0, rd, er, lat);
    check("rd_latency", 64'(lat), 64'd3);
    check("rd_data",    64'(rd),  64'h1234_5678);
    check("rd_err",     64'(er),  64'd0);

    do32(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b0011, rd, er, lat);
    check("wr_err",   64'(er), 64'd0);
    check("wr_rdata", 64'(rd), 64'd0);
    do32(1'b0, 32'h8000_0010, '0, '0, rd, er, lat);
    check("wr_partial_readback", 64'(rd), 64'hCAFE_BEEF);

    c0 = pmem_calls;
    do32(1'b0, 32'h8000_0002, '0, '0, rd, er, lat);
    check("misalign_err",   64'(er), 64'd1);
    check("misalign_rdata", 64'(rd), 64'd0);
    do32(1'b0, 32'h7FFF_FFFC, '0, '0, rd, er, lat);
    check("below_err",   64'(er), 64'd1);
    check("below_rdata", 64'(rd), 64'd0);
    do32(1'b1, 32'h8800_0000, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    check("above_err", 64'(er), 64'd1);
    check("err_no_calls", 64'(pmem_calls), 64'(c0));
    do32(1'b0, 32'h87FF_FFFC, '0, '0, rd, er, lat);
    check("top_word_err",   64'(er), 64'd0);
    check("top_word_calls", 64'(pmem_calls), 64'(c0 + 1));

    c0 = pmem_calls;
    do32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
    check("nomask_err",   64'(er), 64'd0);
    check("nomask_calls", 64'(pmem_calls), 64'(c0));
    do32(1'b0, 32'h8000_0000, '0, '0, rd, er, lat);
    check("nomask_readback", 64'(rd), 64'h1234_5678);

    // Response held while the consumer stalls.
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h8000_0010;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    lat = 1;
    while (!a_rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    for (int i = 0; i < 5; i++) begin
      check("hold_valid",     64'(a_rsp_valid), 64'd1);
      check("hold_rdata",     64'(a_rsp_rdata), 64'hCAFE_BEEF);
      check("hold_err",       64'(a_rsp_err),   64'd0);
      check("hold_req_ready", 64'(a_req_ready), 64'd0);
      @(posedge clk); #1;
    end
    a_rsp_ready = 1'b1; @(posedge clk); #1; a_rsp_ready = 1'b0;
    check("release_valid", 64'(a_rsp_valid), 64'd0);
    check("release_ready", 64'(a_req_ready), 64'd1);

    // Reset while a write is in flight.
    c0 = pmem_calls;
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h8000_0020;
    a_req_wdata = 32'h1111_2222; a_req_wmask = 4'hF;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req_ready", 64'(a_req_ready), 64'd0);
    check("midrst_rsp_valid", 64'(a_rsp_valid), 64'd0);
    check("midrst_rsp_rdata", 64'(a_rsp_rdata), 64'd0);
    check("midrst_rsp_err",   64'(a_rsp_err),   64'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_no_calls", 64'(pmem_calls), 64'(c0));
    check("midrst_mem", 64'($unsigned(pmem_read(32'h8000_0020))), 64'd0);
    check("midrst_ready_back", 64'(a_req_ready), 64'd1);

    do64(1'b1, 32'h8000_0008, 64'h0011_2233_4455_6677, 8'hFF, rd64, er, lat);
    check("w64_latency", 64'(lat), 64'd1);
    check("w64_err",     64'(er),  64'd0);
    check("w64_lo", 64'($unsigned(pmem_read(32'h8000_0008))), 64'h4455_6677);
    check("w64_hi", 64'($unsigned(pmem_read(32'h8000_000C))), 64'h0011_2233);
    do64(1'b0, 32'h8000_0008, '0, '0, rd64, er, lat);
    check("r64_data", rd64, 64'h0011_2233_4455_6677);
    do64(1'b1, 32'h8000_0008, 64'hAAAA_AAAA_BBBB_BBBB, 8'hF0, rd64, er, lat);
    check("w64_hi_only_lo", 64'($unsigned(pmem_read(32'h8000_0008))), 64'h4455_6677);
    check("w64_hi_only_hi", 64'($unsigned(pmem_read(32'h8000_000C))), 64'hAAAA_AAAA);
    do64(1'b0, 32'h8000_0004, '0, '0, rd64, er, lat);
    check("r64_misalign_err",   64'(er), 64'd1);
    check("r64_misalign_rdata", rd64,    64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_24100006_sram.md
YSYX_24100006_SRAM -- requirements
Module: ysyx_24100006_sram

Interface
REQ-001 SHALL have parameter DW, default 32: data width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter AW, default 32: address width in bits.
REQ-003 SHALL have parameter LATENCY, default 1: cycles from request accept to rsp_valid; range 1..15.
REQ-004 SHALL have parameter BASE, default 32'h8000_0000: lowest legal byte address.
REQ-005 SHALL have parameter SIZE, default 32'h0800_0000: legal window size in bytes.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port req_valid, input, 1 bit: request present.
REQ-009 SHALL have port req_ready, output, 1 bit: block can accept a request.
REQ-010 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port req_addr, input, AW bits: byte address.
REQ-012 SHALL have port req_wdata, input, DW bits: write data.
REQ-013 SHALL have port req_wmask, input, DW/8 bits: byte enables for writes.
REQ-014 SHALL have port rsp_valid, output, 1 bit: response present.
REQ-015 SHALL have port rsp_ready, input, 1 bit: consumer accepts the response.
REQ-016 SHALL have port rsp_rdata, output, DW bits: read data; 0 for writes and errors.
REQ-017 SHALL have port rsp_err, output, 1 bit: access fault.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-019 SHALL accept a request on a clock edge with req_valid&req_ready, latching we/addr/wdata/wmask and loading the latency counter with LATENCY-1.
REQ-020 SHALL transition IDLE->RESP directly when the counter load is 0, otherwise IDLE->BUSY; in BUSY, decrement by 1 per cycle and move to RESP on the edge where the counter reaches 0.
REQ-021 SHALL perform the DPI-C access (pmem_write with zero-extended mask, or pmem_read) exactly once, on the edge entering RESP, and register the read result into rsp_rdata.
REQ-022 SHALL, when DW=64, perform two 32-bit DPI-C transactions at addr and addr+4, with the low half first and the mask split 4/4.
REQ-023 SHALL set rsp_err=1, skip the DPI-C call, and drive rsp_rdata=0 when addr<BASE, addr+DW/8>BASE+SIZE, or addr is not aligned to DW/8.
REQ-024 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-025 SHALL NOT accept a new request in the cycle a response completes; back-to-back throughput is one access per LATENCY+1 cycles minimum.
REQ-026 SHALL treat a write with wmask=0 as a legal no-op that makes no DPI-C call, with rsp_err=0.
REQ-027 SHALL use a combinational-free output path: all outputs are driven from registers or the FSM state.

Reset
REQ-028 SHALL, on rst_n=0, immediately force IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0 and req_ready=0.
REQ-029 SHALL drive req_ready=1 from the first clock edge after rst_n deasserts.
REQ-030 SHALL discard an in-flight access on reset mid-operation, so no DPI-C call is made for it.

Configuration
REQ-031 SHALL, with YSYX_24100006_SRAM_RAND_DELAY_EN defined, load the counter with an LFSR value in 0..LATENCY-1, re-drawn at each accept; the LFSR seed is 8'hA5 at reset.
REQ-032 SHALL, without YSYX_24100006_SRAM_RAND_DELAY_EN, use the fixed LATENCY with no LFSR logic present.

Structure
REQ-033 SHALL take the state enum, default BASE/SIZE and DPI-C import declarations from package ysyx_24100006_pkg.
REQ-034 SHALL place the LFSR in sub-module ysyx_24100006_lfsr (8-bit, taps 8,6,5,4), instantiated only when the macro is defined.

Verification
REQ-035 SHALL cover: LATENCY=3, read of 0x8000_0000 holding 0x1234_5678 -> rsp_valid on the 3rd edge after accept, rdata=0x1234_5678, err=0.
REQ-036 SHALL cover: write 0xDEAD_BEEF with mask 4'b0011 to 0x8000_0010, then read -> upper halfword unchanged, lower = 0xBEEF.
REQ-037 SHALL cover: read of 0x8000_0002 (misaligned) and of 0x7FFF_FFFC -> err=1, rdata=0, no DPI-C call.
REQ-038 SHALL cover: rsp_ready held low for 5 cycles -> response stable for all 5 cycles, req_ready=0 throughout.
REQ-039 SHALL cover: rst_n pulsed low while in BUSY -> outputs at reset values immediately, pending write absent from memory.
REQ-040 SHALL cover: DW=64, write 64'h0011_2233_4455_6677 with all-ones mask to 0x8000_0008 -> reads of 0x8000_0008 and 0x8000_000C return 0x4455_6677 and 0x0011_2233.
